// File: rtl/bpu_pkg.sv
// ---------------------------------------------------------------------------
// bpu_pkg -- shared definitions for the gshare branch prediction unit.
//   * default parameter values for history, BTB index and counter widths
//   * bpu_state_t  : INIT (table sweep in progress) / RUN (predicting)
//   * btb_entry_t  : one BTB line {valid, tag, target}
// ---------------------------------------------------------------------------
package bpu_pkg;

  localparam int GHR_W_DEF     = 8;
  localparam int BTB_IDX_W_DEF = 6;
  localparam int CNT_W_DEF     = 2;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } bpu_state_t;

  // The tag field is sized for the widest possible tag so the struct does not
  // depend on the BTB_IDX_W of any particular instance; unused upper tag bits
  // are always written and compared as zero.
  typedef struct packed {
    logic        valid;
    logic [31:0] tag;
    logic [31:0] target;
  } btb_entry_t;

endpackage

// File: rtl/gshare_pht.sv
// ---------------------------------------------------------------------------
// gshare_pht -- pattern history table of saturating counters.
//   i_clk       : clock, rising edge
//   i_rd_idx    : combinational read index (lookup path)
//   o_rd_taken  : MSB of the counter at i_rd_idx (predict taken)
//   i_wr_en     : write enable
//   i_wr_init   : 1 = write weakly-not-taken, 0 = saturating update
//   i_wr_idx    : write index
//   i_wr_taken  : update direction (increment when 1, decrement when 0)
// A write is visible to reads from the following cycle; a same-cycle read of
// the written index returns the old counter.
// ---------------------------------------------------------------------------
module gshare_pht
  import bpu_pkg::*;
#(
  parameter int IDX_W = GHR_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             i_clk,
  input  logic [IDX_W-1:0] i_rd_idx,
  output logic             o_rd_taken,
  input  logic             i_wr_en,
  input  logic             i_wr_init,
  input  logic [IDX_W-1:0] i_wr_idx,
  input  logic             i_wr_taken
);

  localparam int             DEPTH       = 2 ** IDX_W;
  localparam logic [CNT_W-1:0] CNT_MAX     = {CNT_W{1'b1}};
  // MSB clear, all lower bits set: the strongest not-taken value that flips
  // to taken after a single taken update.
  localparam logic [CNT_W-1:0] CNT_WEAK_NT = CNT_MAX >> 1;

  logic [CNT_W-1:0] cnt_mem [DEPTH];
  logic [CNT_W-1:0] wr_cur;
  logic [CNT_W-1:0] wr_cnt_next;

  assign o_rd_taken = cnt_mem[i_rd_idx][CNT_W-1];

  always_comb begin
    wr_cur      = cnt_mem[i_wr_idx];
    wr_cnt_next = wr_cur;
    if (i_wr_init) begin
      wr_cnt_next = CNT_WEAK_NT;
    end else if (i_wr_taken) begin
      if (wr_cur != CNT_MAX) wr_cnt_next = wr_cur + CNT_W'(1);
    end else begin
      if (wr_cur != '0) wr_cnt_next = wr_cur - CNT_W'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_wr_en) cnt_mem[i_wr_idx] <= wr_cnt_next;
  end

endmodule

// File: rtl/gshare_bpu.sv
// ---------------------------------------------------------------------------
// gshare_bpu -- gshare direction predictor with a direct-mapped BTB.
// Fetch side : i_lookup_vld, i_pc -> o_pred_taken, o_pred_target, o_pred_ghr
//              (combinational, same cycle)
// Resolve side: i_res_* -> o_mispred, o_redirect_pc (combinational); table
//              and history updates land at the next edge
// Status     : o_ready (table sweep done), o_br_cnt, o_mispred_cnt
// After reset the unit sweeps every PHT index (one per cycle) to
// weakly-not-taken and clears BTB valid bits, then enters RUN.
// ---------------------------------------------------------------------------
module gshare_bpu
  import bpu_pkg::*;
#(
  parameter int GHR_W     = GHR_W_DEF,
  parameter int BTB_IDX_W = BTB_IDX_W_DEF,
  parameter int CNT_W     = CNT_W_DEF
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_lookup_vld,
  input  logic [31:0]      i_pc,
  output logic             o_ready,
  output logic             o_pred_taken,
  output logic [31:0]      o_pred_target,
  output logic [GHR_W-1:0] o_pred_ghr,
  input  logic             i_res_vld,
  input  logic [31:0]      i_res_pc,
  input  logic [GHR_W-1:0] i_res_ghr,
  input  logic             i_res_taken,
  input  logic [31:0]      i_res_target,
  input  logic             i_res_pred_taken,
  input  logic [31:0]      i_res_pred_target,
  output logic             o_mispred,
  output logic [31:0]      o_redirect_pc,
  output logic [31:0]      o_br_cnt,
  output logic [31:0]      o_mispred_cnt
);

  localparam int BTB_DEPTH = 2 ** BTB_IDX_W;

  bpu_state_t       state_reg, state_next;
  logic [GHR_W-1:0] init_idx_reg, init_idx_next;
  logic [GHR_W-1:0] spec_ghr_reg, spec_ghr_next;
  logic [31:0]      br_cnt_reg, br_cnt_next;
  logic [31:0]      mispred_cnt_reg, mispred_cnt_next;

  btb_entry_t btb_mem [BTB_DEPTH];

  logic in_run;
  assign in_run = (state_reg == RUN);

  // ---------------- lookup ----------------
  logic [GHR_W-1:0]     lk_pht_idx;
  logic [BTB_IDX_W-1:0] lk_btb_idx;
  logic [31:0]          lk_tag;
  btb_entry_t           lk_entry;
  logic                 lk_hit;
  logic                 lk_pht_taken;

  assign lk_pht_idx = i_pc[GHR_W+1:2] ^ spec_ghr_reg;
  assign lk_btb_idx = i_pc[BTB_IDX_W+1:2];
  assign lk_tag     = i_pc >> (BTB_IDX_W + 2);
  assign lk_entry   = btb_mem[lk_btb_idx];
  // BTB contents are undefined until the sweep has cleared them, so a hit
  // only counts in RUN.
  assign lk_hit     = in_run && lk_entry.valid && (lk_entry.tag == lk_tag);

  assign o_ready       = in_run;
  assign o_pred_taken  = lk_hit && lk_pht_taken;
  assign o_pred_target = o_pred_taken ? lk_entry.target : (i_pc + 32'd4);
  assign o_pred_ghr    = spec_ghr_reg;

  // ---------------- resolution ----------------
  logic                 res_act;
  logic [GHR_W-1:0]     res_pht_idx;
  logic [BTB_IDX_W-1:0] res_btb_idx;
  logic [31:0]          res_tag;

  assign res_act     = in_run && i_res_vld;
  assign res_pht_idx = i_res_pc[GHR_W+1:2] ^ i_res_ghr;
  assign res_btb_idx = i_res_pc[BTB_IDX_W+1:2];
  assign res_tag     = i_res_pc >> (BTB_IDX_W + 2);

  assign o_mispred = res_act &&
                     ((i_res_taken != i_res_pred_taken) ||
                      (i_res_taken && (i_res_target != i_res_pred_target)));
  assign o_redirect_pc = i_res_taken ? i_res_target : (i_res_pc + 32'd4);

  assign o_br_cnt      = br_cnt_reg;
  assign o_mispred_cnt = mispred_cnt_reg;

  // ---------------- PHT ----------------
  // The sweep and resolution updates share the single write port; they are
  // mutually exclusive because resolutions are ignored in INIT.
  gshare_pht #(
    .IDX_W (GHR_W),
    .CNT_W (CNT_W)
  ) u_pht (
    .i_clk      (i_clk),
    .i_rd_idx   (lk_pht_idx),
    .o_rd_taken (lk_pht_taken),
    .i_wr_en    (!in_run || res_act),
    .i_wr_init  (!in_run),
    .i_wr_idx   (in_run ? res_pht_idx : init_idx_reg),
    .i_wr_taken (i_res_taken)
  );

  // ---------------- BTB write port ----------------
  logic                 btb_we;
  logic [BTB_IDX_W-1:0] btb_wr_idx;
  btb_entry_t           btb_wr_data;

  always_comb begin
    btb_we      = 1'b0;
    btb_wr_idx  = res_btb_idx;
    btb_wr_data = '0;
    if (!in_run) begin
      // Only the first BTB_DEPTH sweep indices map onto BTB lines.
      btb_we     = (32'(init_idx_reg) < BTB_DEPTH);
      btb_wr_idx = init_idx_reg[BTB_IDX_W-1:0];
    end else if (res_act && i_res_taken) begin
      btb_we             = 1'b1;
      btb_wr_data.valid  = 1'b1;
      btb_wr_data.tag    = res_tag;
      btb_wr_data.target = i_res_target;
    end
  end

  always_ff @(posedge i_clk) begin
    if (btb_we) btb_mem[btb_wr_idx] <= btb_wr_data;
  end

  // ---------------- control ----------------
  always_comb begin
    state_next       = state_reg;
    init_idx_next    = init_idx_reg;
    spec_ghr_next    = spec_ghr_reg;
    br_cnt_next      = br_cnt_reg;
    mispred_cnt_next = mispred_cnt_reg;
    case (state_reg)
      INIT: begin
        init_idx_next = init_idx_reg + GHR_W'(1);
        if (&init_idx_reg) state_next = RUN;
      end
      RUN: begin
        // A mispredict repairs history from the branch's own snapshot and
        // wins over any speculative shift from a same-cycle fetch.
        if (o_mispred)
          spec_ghr_next = {i_res_ghr[GHR_W-2:0], i_res_taken};
        else if (i_lookup_vld && lk_hit)
          spec_ghr_next = {spec_ghr_reg[GHR_W-2:0], o_pred_taken};
        if (res_act)   br_cnt_next      = br_cnt_reg + 32'd1;
        if (o_mispred) mispred_cnt_next = mispred_cnt_reg + 32'd1;
      end
      default: state_next = INIT;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_reg       <= INIT;
      init_idx_reg    <= '0;
      spec_ghr_reg    <= '0;
      br_cnt_reg      <= '0;
      mispred_cnt_reg <= '0;
    end else begin
      state_reg       <= state_next;
      init_idx_reg    <= init_idx_next;
      spec_ghr_reg    <= spec_ghr_next;
      br_cnt_reg      <= br_cnt_next;
      mispred_cnt_reg <= mispred_cnt_next;
    end
  end

endmodule
